debug_uart_responder: RTL and testbench

- Client-bound half of the debug UART protocol: serializes the debug unit's replies back to the host PC over `uart_tx`.
- Replies are `OP_OK` (answer to `OP_PING`) and `OP_SIGNAL` (a PC plus CPU signal snapshot, sent on pause, breakpoint or step).
- Sits beside the debug command receiver inside the debug core.
- Owns all frame sequencing: opcode byte first, then payload, 8N1, LSB first, idle-high line.

---
 rtl/debug_uart_responder.sv | 181 ++++++++++++++++++
 tb/tb_debug_uart_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_responder.sv
// debug_uart_responder
// Serializes debug-unit replies (OP_OK, OP_SIGNAL) onto an 8N1, LSB-first,
// idle-high UART line. Requests are latched as pending flags and launched
// from IDLE, OK first. All outputs are registered, so the line follows the
// internal state by one clock.

module debug_uart_responder #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  OP_SIGNAL    = 8'h01,
    parameter logic [7:0]  OP_OK        = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_ok,
    input  logic        req_signal,
    input  logic [31:0] pc,
    input  logic [31:0] signals,
    output logic        uart_tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int            TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic          pend_ok_r, pend_ok_s;
    logic          pend_sig_r, pend_sig_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [3:0]    byte_idx_r, byte_idx_s;
    logic [7:0]    shift_r, shift_s;
    logic [63:0]   snap_r, snap_s;
    logic          is_sig_r, is_sig_s;
    logic          done_r, done_s;
    logic          tx_s, busy_s, tick_s;
    logic          launch_ok_s, launch_sig_s;

    // Select payload byte idx (0 = pc[7:0] ... 7 = signals[31:24]) from the snapshot.
    function automatic logic [7:0] payload_byte(input logic [63:0] snap, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = snap[7:0];
            3'd1:    b = snap[15:8];
            3'd2:    b = snap[23:16];
            3'd3:    b = snap[31:24];
            3'd4:    b = snap[39:32];
            3'd5:    b = snap[47:40];
            3'd6:    b = snap[55:48];
            3'd7:    b = snap[63:56];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next-state, byte sequencing, pending-flag update and line value.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        bit_idx_s    = bit_idx_r;
        byte_idx_s   = byte_idx_r;
        shift_s      = shift_r;
        snap_s       = snap_r;
        is_sig_s     = is_sig_r;
        done_s       = 1'b0;
        tx_s         = 1'b1;
        launch_ok_s  = 1'b0;
        launch_sig_s = 1'b0;
        tick_s       = (timer_r == T_LAST);
        case (state_r)
            ST_IDLE: begin
                timer_s = TW'(0);
                if (pend_ok_r) begin
                    launch_ok_s = 1'b1;
                    is_sig_s    = 1'b0;
                    shift_s     = OP_OK;
                    byte_idx_s  = 4'd0;
                    state_s     = ST_START;
                end else if (pend_sig_r) begin
                    launch_sig_s = 1'b1;
                    is_sig_s     = 1'b1;
                    shift_s      = OP_SIGNAL;
                    snap_s       = {signals, pc};
                    byte_idx_s   = 4'd0;
                    state_s      = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                tx_s = 1'b0;
                if (tick_s) begin
                    timer_s   = TW'(0);
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_DATA: begin
                tx_s = shift_r[bit_idx_r];
                if (tick_s) begin
                    timer_s = TW'(0);
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (tick_s) begin
                    timer_s = TW'(0);
                    // byte_idx counts payload bytes already loaded; 8 means the frame is complete
                    if (is_sig_r && (byte_idx_r < 4'd8)) begin
                        shift_s    = payload_byte(snap_r, byte_idx_r[2:0]);
                        byte_idx_s = byte_idx_r + 4'd1;
                        state_s    = ST_START;
                    end else begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // A request in the launch cycle re-arms its flag.
        pend_ok_s  = req_ok     | (pend_ok_r  & ~launch_ok_s);
        pend_sig_s = req_signal | (pend_sig_r & ~launch_sig_s);
        busy_s     = (state_r != ST_IDLE);
    end

    // State, datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pend_ok_r  <= 1'b0;
            pend_sig_r <= 1'b0;
            timer_r    <= TW'(0);
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 4'd0;
            shift_r    <= 8'h00;
            snap_r     <= 64'h0;
            is_sig_r   <= 1'b0;
            done_r     <= 1'b0;
            uart_tx    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            pend_ok_r  <= pend_ok_s;
            pend_sig_r <= pend_sig_s;
            timer_r    <= timer_s;
            bit_idx_r  <= bit_idx_s;
            byte_idx_r <= byte_idx_s;
            shift_r    <= shift_s;
            snap_r     <= snap_s;
            is_sig_r   <= is_sig_s;
            done_r     <= done_s;
            uart_tx    <= tx_s;
            busy       <= busy_s;
            frame_done <= done_r;
        end
    end

endmodule

// File: tb/tb_debug_uart_responder.sv
// Testbench for debug_uart_responder: decodes the serial line and compares
// the received byte stream, timing and handshake counts with frames built
// from the protocol rules.

module tb_debug_uart_responder;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_ok;
    logic        req_signal;
    logic [31:0] pc;
    logic [31:0] signals;
    logic        uart_tx;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] exp_q[$];
    int         busy_cnt = 0;
    int         fd_cnt = 0;

    debug_uart_responder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_ok     (req_ok),
        .req_signal (req_signal),
        .pc         (pc),
        .signals    (signals),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line decoder and busy / frame_done counters, sampled on the falling edge.
    initial begin : monitor
        bit         dec_active;
        int         dec_cnt;
        int         dec_start;
        int         bit_no;
        logic [7:0] dec_byte;
        dec_active = 1'b0;
        dec_cnt    = 0;
        dec_start  = 0;
        dec_byte   = 8'h00;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
            if (rst_n !== 1'b1) begin
                dec_active = 1'b0;
            end else if (!dec_active) begin
                if (uart_tx === 1'b0) begin
                    dec_active = 1'b1;
                    dec_cnt    = 0;
                    dec_start  = cyc;
                end
            end else begin
                dec_cnt++;
                if ((dec_cnt % CPB) == (CPB / 2)) begin
                    bit_no = dec_cnt / CPB;
                    if (bit_no == 0) begin
                        check_val("start_bit", 32'(uart_tx), 32'd0);
                    end else if (bit_no <= 8) begin
                        dec_byte[bit_no-1] = uart_tx;
                    end else begin
                        check_val("stop_bit", 32'(uart_tx), 32'd1);
                        rx_q.push_back(dec_byte);
                        rx_t.push_back(dec_start);
                        dec_active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic clear_obs();
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        busy_cnt = 0;
        fd_cnt   = 0;
    endtask

    // Expected bytes of one frame from the protocol layout.
    task automatic push_frame(input bit is_sig, input logic [31:0] p, input logic [31:0] s);
        if (!is_sig) begin
            exp_q.push_back(8'h02);
        end else begin
            exp_q.push_back(8'h01);
            for (int i = 0; i < 4; i++) exp_q.push_back(p[8*i +: 8]);
            for (int i = 0; i < 4; i++) exp_q.push_back(s[8*i +: 8]);
        end
    endtask

    // One-cycle request pulse; returns the cycle of the sampling edge.
    task automatic pulse(input bit ok, input bit sg, output int k);
        @(negedge clk);
        req_ok     = ok;
        req_signal = sg;
        @(negedge clk);
        req_ok     = 1'b0;
        req_signal = 1'b0;
        k = cyc;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int i;
        i = 0;
        while ((fd_cnt < n) && (i < budget)) begin
            @(negedge clk);
            i++;
        end
        wait_cycles(4);
    endtask

    task automatic check_frames(input string tag, input int frames, input int busy_exp);
        check_val({tag, "_frame_done"}, 32'(fd_cnt), 32'(frames));
        check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(busy_exp));
        check_val({tag, "_byte_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check_val($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    task automatic run_sig(input logic [31:0] p, input logic [31:0] s, input bit change_mid);
        int k;
        clear_obs();
        pc      = p;
        signals = s;
        pulse(1'b0, 1'b1, k);
        push_frame(1'b1, p, s);
        if (change_mid) begin
            wait_cycles(20 * CPB);
            pc      = 32'hFFFF_FFFF;
            signals = $urandom;
        end
        wait_frames(1, 200 * CPB);
        check_frames("sig", 1, 90 * CPB);
        if (rx_t.size() == 9) begin
            check_val("sig_latency", 32'(rx_t[0]), 32'(k + 2));
            for (int i = 1; i < 9; i++)
                check_val($sformatf("sig_gap%0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'(10 * CPB));
        end else begin
            check_val("sig_start_count", 32'(rx_t.size()), 32'd9);
        end
    endtask

    initial begin : main
        int k;
        logic [31:0] p2, s2;
        rst_n      = 1'b0;
        req_ok     = 1'b0;
        req_signal = 1'b0;
        pc         = 32'h0;
        signals    = 32'h0;
        wait_cycles(3);
        check_val("rst_uart_tx", 32'(uart_tx), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        wait_cycles(3);

        // OK frame from idle
        clear_obs();
        pulse(1'b1, 1'b0, k);
        push_frame(1'b0, 32'h0, 32'h0);
        wait_frames(1, 40 * CPB);
        check_frames("ok", 1, 10 * CPB);
        check_val("ok_latency", 32'((rx_t.size() > 0) ? rx_t[0] : -1), 32'(k + 2));

        // SIGNAL frames: fixed pattern, mid-frame pc change, then random
        run_sig(32'h0000_0018, 32'hA5C3_0F01, 1'b0);
        run_sig(32'h0000_0018, 32'hA5C3_0F01, 1'b1);
        for (int i = 0; i < 4; i++) run_sig($urandom, $urandom, 1'($urandom_range(0, 1)));

        // OK and SIGNAL together; values change while SIGNAL is still queued
        clear_obs();
        pc      = $urandom;
        signals = $urandom;
        pulse(1'b1, 1'b1, k);
        push_frame(1'b0, 32'h0, 32'h0);
        wait_cycles(5 * CPB);
        p2      = $urandom;
        s2      = $urandom;
        pc      = p2;
        signals = s2;
        push_frame(1'b1, p2, s2);
        wait_frames(2, 300 * CPB);
        check_frames("both", 2, 100 * CPB);
        check_val("both_idle_gap", 32'((rx_t.size() > 1) ? rx_t[1] - rx_t[0] : -1), 32'(10 * CPB + 1));

        // Three SIGNAL requests during an OK frame merge into one
        clear_obs();
        pc      = $urandom;
        signals = $urandom;
        pulse(1'b1, 1'b0, k);
        push_frame(1'b0, 32'h0, 32'h0);
        wait_cycles(2 * CPB);
        pulse(1'b0, 1'b1, k);
        wait_cycles(CPB);
        pulse(1'b0, 1'b1, k);
        wait_cycles(CPB);
        pulse(1'b0, 1'b1, k);
        push_frame(1'b1, pc, signals);
        wait_frames(2, 300 * CPB);
        wait_cycles(30 * CPB);
        check_frames("merge", 2, 100 * CPB);

        // Reset during bit 4 of the first payload byte
        clear_obs();
        pc      = $urandom;
        signals = $urandom;
        pulse(1'b0, 1'b1, k);
        while (cyc < k + 2 + 15 * CPB + 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("abort_uart_tx", 32'(uart_tx), 32'd1);
        check_val("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        wait_cycles(40 * CPB);
        check_val("abort_quiet_bytes", 32'(rx_q.size()), 32'd0);
        check_val("abort_quiet_busy", 32'(busy_cnt), 32'd0);
        check_val("abort_quiet_done", 32'(fd_cnt), 32'd0);

        // Still functional afterwards
        clear_obs();
        pulse(1'b1, 1'b0, k);
        push_frame(1'b0, 32'h0, 32'h0);
        wait_frames(1, 40 * CPB);
        check_frames("post_rst_ok", 1, 10 * CPB);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
